intan_acq_engine: RTL

Parametrised successor of the single-pair Intan serial acquisition core. It drives one shared CSn/SCLK/COPI command stream and samples NUM_CIPO independent CIPO lines, each with its own cable-delay phase setting. Results go into a frame-packetised 32-bit FIFO stream: a magic/timestamp header, then one word per line per command cycle. New relative to the previous core: whole-frame FIFO admission with drop counting, exact loop-count termination, and per-line DDR (A/B) word assembly. It sits between the AXI control-register wrapper and the FIFO that feeds the PS-facing BRAM.

---
 rtl/intan_acq_pkg.sv | 30 +++
 rtl/intan_acq_engine_cipo_line_sampler.sv | 48 ++++
 rtl/intan_acq_engine.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/intan_acq_pkg.sv
// Shared constants for the Intan acquisition engine: frame magics, sequencer
// state positions, phase limit and the frame-size helper.
package intan_acq_pkg;

  localparam logic [31:0] MAGIC_0 = 32'hDEAD_BEEF;
  localparam logic [31:0] MAGIC_1 = 32'hCAFE_BABE;

  localparam logic [6:0] LAST_STATE   = 7'd79;
  localparam logic [6:0] CSN_LAST     = 7'd65;
  localparam logic [6:0] SCLK_LAST    = 7'd63;
  localparam logic [6:0] SAMPLE_FIRST = 7'd2;
  localparam logic [6:0] SAMPLE_LAST  = 7'd75;
  localparam logic [6:0] CAPTURE      = 7'd76;
  localparam logic [6:0] WRITE_FIRST  = 7'd77;

  localparam logic [3:0] MAX_PHASE = 4'd11;
  localparam int         BUF_BITS  = 74;

  typedef enum logic [1:0] {
    RUN_IDLE,
    RUN_ACTIVE,
    RUN_DONE
  } run_state_t;

  // Header (magic x2, timestamp x2) plus one word per line per command cycle.
  function automatic int frame_words(input int cycles, input int lines);
    return 4 + cycles * lines;
  endfunction

endpackage

// File: rtl/intan_acq_engine_cipo_line_sampler.sv
// One CIPO line: 74-bit oversample buffer and phase-selected {B,A} DDR word
// capture at the end of each command cycle.
module cipo_line_sampler
  import intan_acq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [6:0]  state,
  input  logic [3:0]  phase,
  input  logic        cipo,
  output logic [31:0] word
);

  logic [BUF_BITS-1:0] line_buf;
  logic [3:0]          phase_eff;
  logic [15:0]         a_bits;
  logic [15:0]         b_bits;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    a_bits    = '0;
    b_bits    = '0;
    phase_eff = (phase > MAX_PHASE) ? MAX_PHASE : phase;
    for (int n = 0; n < 16; n++) begin
      a_bits[15-n] = line_buf[4*n + int'(phase_eff)];
      b_bits[15-n] = line_buf[4*n + int'(phase_eff) + 2];
    end
  end

  // NOTE: line_buf has no reset: all 74 bits are rewritten during states
  // 2..75 of a cycle before the capture at state 76 reads them.
  always_ff @(posedge clk) begin
    if (sample_en && state >= SAMPLE_FIRST && state <= SAMPLE_LAST)
      line_buf[state - SAMPLE_FIRST] <= cipo;
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst)
      word <= '0;
    else if (sample_en && state == CAPTURE)
      word <= {b_bits, a_bits};
  end

endmodule

// File: rtl/intan_acq_engine.sv
// Intan serial acquisition engine: shared command stream, NUM_CIPO sampled lines,
// frame-admitted FIFO output. Define INTAN_ACQ_DEBUG_PATTERN_EN for pattern data.
module intan_acq_engine
  import intan_acq_pkg::*;
#(
  parameter int NUM_CIPO   = 2,
  parameter int CYCLES     = 35,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          reset_timestamp,
  input  logic [31:0]                   loop_count,
  input  logic [4*NUM_CIPO-1:0]         phase,
  input  logic [16*CYCLES-1:0]          copi_words,
  output logic                          fifo_write_en,
  output logic [31:0]                   fifo_write_data,
  input  logic                          fifo_full,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          csn,
  output logic                          sclk,
  output logic                          copi,
  input  logic [NUM_CIPO-1:0]           cipo,
  output logic                          active,
  output logic                          loop_done,
  output logic [6:0]                    state_counter,
  output logic [5:0]                    cycle_counter,
  output logic [31:0]                   frames_sent,
  output logic [31:0]                   frames_dropped,
  output logic [63:0]                   timestamp
);

  localparam int         FRAME_WORDS = frame_words(CYCLES, NUM_CIPO);
  localparam logic [5:0] LAST_CYCLE  = 6'(CYCLES - 1);

  run_state_t                 run_state;
  logic [31:0]                frame_index;
  logic                       admitted;
  logic [NUM_CIPO-1:0][31:0]  words;

  logic        boundary;
  logic        stop_hit;
  logic        will_run;
  logic [31:0] fifo_free;
  logic        room_ok;

  assign boundary  = (state_counter == LAST_STATE) && (cycle_counter == LAST_CYCLE);
  assign stop_hit  = (loop_count != 32'd0) && (frame_index == loop_count);
  assign will_run  = enable && ((run_state == RUN_IDLE) ||
                                (run_state == RUN_ACTIVE && !stop_hit));
  // Signed view guards against an occupancy report above FIFO_DEPTH.
  assign fifo_free = 32'(FIFO_DEPTH) - 32'(fifo_count);
  assign room_ok   = !fifo_free[31] && (fifo_free >= 32'(FRAME_WORDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_counter <= '0;
      cycle_counter <= '0;
    end else if (state_counter == LAST_STATE) begin
      state_counter <= '0;
      cycle_counter <= (cycle_counter == LAST_CYCLE) ? '0 : cycle_counter + 6'd1;
    end else begin
      state_counter <= state_counter + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_state      <= RUN_IDLE;
      active         <= 1'b0;
      loop_done      <= 1'b0;
      frame_index    <= 32'd1;
      admitted       <= 1'b0;
      timestamp      <= '0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else if (boundary) begin
      timestamp <= (!enable && reset_timestamp) ? 64'd0 : timestamp + 64'd1;
      if (admitted)
        frames_sent <= frames_sent + 32'd1;
      admitted <= will_run && room_ok;
      if (will_run && !room_ok)
        frames_dropped <= frames_dropped + 32'd1;
      if (!enable) begin
        run_state <= RUN_IDLE;
        active    <= 1'b0;
        loop_done <= 1'b0;
      end else begin
        case (run_state)
          RUN_IDLE: begin
            run_state   <= RUN_ACTIVE;
            active      <= 1'b1;
            frame_index <= 32'd1;
          end
          RUN_ACTIVE: begin
            if (stop_hit) begin
              run_state <= RUN_DONE;
              active    <= 1'b0;
              loop_done <= 1'b1;
            end else begin
              frame_index <= frame_index + 32'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csn  <= 1'b1;
      sclk <= 1'b0;
      copi <= 1'b0;
    end else begin
      csn  <= !(active && state_counter <= CSN_LAST);
      sclk <= active && state_counter[1] && (state_counter <= SCLK_LAST);
      copi <= active && (state_counter <= SCLK_LAST) &&
              copi_words[{cycle_counter, ~state_counter[5:2]}];
    end
  end

  for (genvar k = 0; k < NUM_CIPO; k++) begin : g_line
`ifdef INTAN_ACQ_DEBUG_PATTERN_EN
    always_ff @(posedge clk) begin
      if (rst)
        words[k] <= '0;
      else if (active && state_counter == CAPTURE)
        words[k] <= {2'(k), cycle_counter, timestamp[23:0]};
    end
`else
    cipo_line_sampler u_sampler (
      .clk       (clk),
      .rst       (rst),
      .sample_en (active),
      .state     (state_counter),
      .phase     (phase[4*k +: 4]),
      .cipo      (cipo[k]),
      .word      (words[k])
    );
`endif
  end

  logic        header_slot;
  logic        line_slot;
  logic [31:0] header_word;
  logic [31:0] line_word;

  always_comb begin
    header_slot = (cycle_counter == 6'd0) && (state_counter <= 7'd3);
    line_slot   = (state_counter >= WRITE_FIRST) &&
                  (state_counter < WRITE_FIRST + 7'(NUM_CIPO));
    case (state_counter[1:0])
      2'd0:    header_word = MAGIC_0;
      2'd1:    header_word = MAGIC_1;
      2'd2:    header_word = timestamp[31:0];
      default: header_word = timestamp[63:32];
    endcase
    line_word = '0;
    for (int k = 0; k < NUM_CIPO; k++)
      if (state_counter == WRITE_FIRST + 7'(k))
        line_word = words[k];
  end

  // A full FIFO only suppresses the individual write; the frame still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_write_en   <= 1'b0;
      fifo_write_data <= '0;
    end else begin
      fifo_write_en <= 1'b0;
      if (admitted && !fifo_full) begin
        if (header_slot) begin
          fifo_write_en   <= 1'b1;
          fifo_write_data <= header_word;
        end else if (line_slot) begin
          fifo_write_en   <= 1'b1;
          fifo_write_data <= line_word;
        end
      end
    end
  end

endmodule
